axil_cfg_master: RTL and testbench
==================================

Name: axil_cfg_master

Overview:
- AXI4-Lite initiator that turns single register commands from a simple valid/ready command port into AXI-Lite write or read transactions.
- Returns the completion (read data and response code) on a valid/ready response port.
- Connects to the s_axil_* slave port of top_ram, so the configuration registers are programmed over the bus rather than by direct hierarchical access.
- Keeps saturating write, read and error counters for debug.

Parameters:
- ADDR_WIDTH, 40: AXI-Lite address width; matches the top_ram s_axil address width.
- DATA_WIDTH, 32: AXI-Lite data width.
- STRB_WIDTH, 4: write strobe width; must equal DATA_WIDTH/8.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  STRB_WIDTH  write byte strobes; ignored for reads.
- rsp_valid  out  1  completion present.
- rsp_ready  in  1  completion consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- rsp_write  out  1  echo of cmd_write.
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master channels. Widths follow ADDR_WIDTH, DATA_WIDTH and STRB_WIDTH; prot and resp are 3 and 2 bits.
- cnt_wr  out  CNT_WIDTH  completed writes.
- cnt_rd  out  CNT_WIDTH  completed reads.
- cnt_err  out  CNT_WIDTH  completions with resp != 0.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - FSM goes to IDLE.
  - All valid and ready outputs go to 0, except cmd_ready, which is 1 in IDLE.
  - rsp_rdata, rsp_resp, rsp_write and the address/data registers clear to 0.
  - Counters clear to 0.
  - Reset mid-transaction abandons the transaction; the slave must be reset in the same cycle.
- awprot and arprot are constant 0. All AXI outputs are driven from registers.
- FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, capture the command into registers.
  - Next state is WR if cmd_write = 1, otherwise RD_A.
- WR:
  - awvalid and wvalid are both asserted in the first cycle after acceptance.
  - Each valid drops independently in the cycle after its own ready handshake. Internal flags aw_done and w_done track this.
  - Valids never deassert before their handshake. Address, data and strobe stay stable while valid.
  - AW and W may complete in the same cycle or in either order.
  - When both handshakes are done, go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0 and rsp_write = 1, then go to RSP.
  - bready is 0 in every other state.
- RD_A: arvalid = 1 until arready; then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid, capture rdata and rresp, set rsp_write = 0, then go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready.
  - On the rsp_valid & rsp_ready cycle, return to IDLE. cmd_ready is high in the following cycle, not the same one.
- Throughput: one transaction outstanding; no pipelining.
- Minimum latency with all readies and responses immediate:
  - cmd accepted at cycle N.
  - AW/W or AR handshake at N+1.
  - B or R handshake at N+2.
  - rsp_valid at N+3.
- Counters:
  - On the completion handshake in RSP, increment cnt_wr or cnt_rd.
  - Also increment cnt_err if rsp_resp != 0.
  - Counters saturate at all-ones and never wrap.
  - If a completion arrives while a counter is at all-ones, that counter holds and the others still increment.
- Unexpected bvalid or rvalid outside WR_B or RD_R is not accepted, because bready and rready are 0 there.

Test Plan:
- Write 0xDEADBEEF, addr 0x10, strb 0xF, slave always ready, BRESP 0 -> AW/W handshake at N+1, rsp_valid at N+3, rsp_resp = 0, cnt_wr = 1.
- Write with wready at N+1 but awready delayed 4 cycles -> wvalid drops at N+2, awvalid stays high with stable awaddr until its handshake, exactly one B accepted, single rsp.
- Read addr 0x20, slave returns rdata 0x12345678 after 5-cycle rvalid delay -> rready held throughout, rsp_rdata = 0x12345678, rsp_write = 0, cnt_rd = 1.
- Write with BRESP 2 (SLVERR) and read with RRESP 3 -> rsp_resp 2 then 3, cnt_err = 2, cnt_wr = 1, cnt_rd = 1.
- Two back-to-back commands with rsp_ready low for 10 cycles -> rsp_* stable, cmd_ready stays 0, second command accepted only the cycle after the first rsp handshake.
- Assert rst while awvalid is high and awready is low -> next cycle all valids are 0, cmd_ready = 1, counters are 0, and a following write completes normally.

Source files
------------

// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: one register command in, one AXI-Lite transaction out,
// completion returned on a response port, plus saturating debug counters.
module axil_cfg_master #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic [CNT_WIDTH-1:0]  cnt_wr,
    output logic [CNT_WIDTH-1:0]  cnt_rd,
    output logic [CNT_WIDTH-1:0]  cnt_err
);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fire;
    logic   w_fire;

    assign m_axil_awprot = '0;
    assign m_axil_arprot = '0;

    assign aw_fire = m_axil_awvalid & m_axil_awready;
    assign w_fire  = m_axil_wvalid & m_axil_wready;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            rsp_write      <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            cnt_wr         <= '0;
            cnt_rd         <= '0;
            cnt_err        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready     <= 1'b0;
                        m_axil_awaddr <= cmd_addr;
                        m_axil_araddr <= cmd_addr;
                        m_axil_wdata  <= cmd_wdata;
                        m_axil_wstrb  <= cmd_wstrb;
                        if (cmd_write) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            aw_done        <= 1'b0;
                            w_done         <= 1'b0;
                            state          <= WR;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (aw_fire) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axil_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    // Done flags or this cycle's handshake: AW and W may finish together or in either order.
                    if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                        m_axil_bready <= 1'b1;
                        state         <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_write     <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RD_A: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_resp      <= m_axil_rresp;
                        rsp_write     <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                        if (rsp_write) cnt_wr <= sat_inc(cnt_wr);
                        else           cnt_rd <= sat_inc(cnt_rd);
                        if (rsp_resp != 2'b00) cnt_err <= sat_inc(cnt_err);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a delay-configurable AXI-Lite slave model.
module tb_axil_cfg_master;

    localparam int AW = 40;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_write;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_awvalid;
    logic          m_axil_awready = 1'b0;
    logic [DW-1:0] m_axil_wdata;
    logic [SW-1:0] m_axil_wstrb;
    logic          m_axil_wvalid;
    logic          m_axil_wready = 1'b0;
    logic [1:0]    m_axil_bresp = '0;
    logic          m_axil_bvalid = 1'b0;
    logic          m_axil_bready;
    logic [AW-1:0] m_axil_araddr;
    logic [2:0]    m_axil_arprot;
    logic          m_axil_arvalid;
    logic          m_axil_arready = 1'b0;
    logic [DW-1:0] m_axil_rdata = '0;
    logic [1:0]    m_axil_rresp = '0;
    logic          m_axil_rvalid = 1'b0;
    logic          m_axil_rready;
    logic [CW-1:0] cnt_wr;
    logic [CW-1:0] cnt_rd;
    logic [CW-1:0] cnt_err;

    axil_cfg_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STRB_WIDTH(SW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .cnt_wr(cnt_wr), .cnt_rd(cnt_rd), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave configuration (written by the main sequence only).
    int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]    bresp_cfg = '0, rresp_cfg = '0;
    logic [DW-1:0] rdata_cfg = '0;
    logic [AW-1:0] exp_awaddr = '0;

    // Slave state and observations (written by the slave process only).
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic          aw_pend, w_pend, ar_pend, b_fire, r_fire, rst_seen;
    int            aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    int            aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
    int            viol, addr_unstable, rready_gap;
    logic [AW-1:0] awaddr_hs, araddr_hs;
    logic [DW-1:0] wdata_hs;
    logic [SW-1:0] wstrb_hs;

    initial begin
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_fire = 0; r_fire = 0; rst_seen = 1;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; rsp_hs = 0;
        aw_cyc = 0; w_cyc = 0; b_cyc = 0; ar_cyc = 0; r_cyc = 0;
        viol = 0; addr_unstable = 0; rready_gap = 0;
        awaddr_hs = '0; araddr_hs = '0; wdata_hs = '0; wstrb_hs = '0;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            if (rst) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0; b_fire = 0; r_fire = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; rsp_hs = 0;
                viol = 0; addr_unstable = 0; rready_gap = 0;
            end else begin
                if (m_axil_awvalid && aw_pend) viol++;
                if (m_axil_wvalid && w_pend) viol++;
                if (m_axil_awvalid && m_axil_awaddr != exp_awaddr) addr_unstable++;
                if (ar_pend && !m_axil_rready) rready_gap++;
                if (m_axil_awvalid && m_axil_awready) begin
                    aw_hs++; aw_cyc = cyc; aw_pend = 1; awaddr_hs = m_axil_awaddr;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    w_hs++; w_cyc = cyc; w_pend = 1; wdata_hs = m_axil_wdata; wstrb_hs = m_axil_wstrb;
                end
                if (m_axil_bvalid && m_axil_bready) begin
                    b_hs++; b_cyc = cyc; b_fire = 1;
                end
                if (m_axil_arvalid && m_axil_arready) begin
                    ar_hs++; ar_cyc = cyc; ar_pend = 1; araddr_hs = m_axil_araddr;
                end
                if (m_axil_rvalid && m_axil_rready) begin
                    r_hs++; r_cyc = cyc; r_fire = 1;
                end
                if (rsp_valid && rsp_ready) rsp_hs++;
            end
            @(negedge clk);
            if (rst_seen) begin
                m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = '0;
                m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rresp = '0; m_axil_rdata = '0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                m_axil_awready = m_axil_awvalid && (aw_wait == aw_delay);
                if (!m_axil_awvalid) aw_wait = 0; else if (!m_axil_awready) aw_wait++;
                m_axil_wready = m_axil_wvalid && (w_wait == w_delay);
                if (!m_axil_wvalid) w_wait = 0; else if (!m_axil_wready) w_wait++;
                m_axil_arready = m_axil_arvalid && (ar_wait == ar_delay);
                if (!m_axil_arvalid) ar_wait = 0; else if (!m_axil_arready) ar_wait++;
                if (b_fire) begin
                    m_axil_bvalid = 0; b_fire = 0; aw_pend = 0; w_pend = 0; b_wait = 0;
                end else if (aw_pend && w_pend && !m_axil_bvalid) begin
                    if (b_wait == b_delay) begin m_axil_bvalid = 1; m_axil_bresp = bresp_cfg; end
                    else b_wait++;
                end
                if (r_fire) begin
                    m_axil_rvalid = 0; r_fire = 0; ar_pend = 0; r_wait = 0;
                end else if (ar_pend && !m_axil_rvalid) begin
                    if (r_wait == r_delay) begin
                        m_axil_rvalid = 1; m_axil_rdata = rdata_cfg; m_axil_rresp = rresp_cfg;
                    end else r_wait++;
                end
            end
        end
    end

    logic [DW-1:0] r_rdata;
    logic [1:0]    r_resp;
    logic          r_write;

    task automatic do_reset();
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bresp_cfg = '0; rresp_cfg = '0; rdata_cfg = '0;
        @(negedge clk);
        rst = 1; cmd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int acc);
        int t;
        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        acc = -1; t = 0;
        while (acc < 0 && t < 200) begin
            @(posedge clk);
            if (cmd_ready) acc = cyc;
            t++;
        end
        check("cmd_accepted", 64'(acc >= 0), 64'd1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int at);
        int t;
        at = -1; t = 0;
        while (at < 0 && t < 200) begin
            @(posedge clk);
            if (rsp_valid && rsp_ready) begin
                at = cyc; r_rdata = rsp_rdata; r_resp = rsp_resp; r_write = rsp_write;
            end
            t++;
        end
        check("rsp_seen", 64'(at >= 0), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, at, hs1, hold_err, cmdrdy_err, t;
        logic [DW-1:0] s_rdata;
        logic [1:0]    s_resp;
        logic          s_write;

        // Reset state and minimum-latency write.
        do_reset();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}, 0);
        check("rst_readys", {m_axil_bready, m_axil_rready}, 0);
        check("rst_cnt", {cnt_wr, cnt_rd, cnt_err}, 0);
        check("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
        exp_awaddr = 40'h10;
        send(1, 40'h10, 32'hDEADBEEF, 4'hF, acc);
        wait_rsp(at);
        check("t1_aw_cyc", aw_cyc, acc + 1);
        check("t1_w_cyc", w_cyc, acc + 1);
        check("t1_b_cyc", b_cyc, acc + 2);
        check("t1_rsp_cyc", at, acc + 3);
        check("t1_awaddr", awaddr_hs, 40'h10);
        check("t1_wdata", wdata_hs, 32'hDEADBEEF);
        check("t1_wstrb", wstrb_hs, 4'hF);
        check("t1_rsp", {r_rdata, r_resp, r_write}, {32'h0, 2'd0, 1'b1});
        @(negedge clk);
        check("t1_cnt_wr", cnt_wr, 1);
        check("t1_cnt_rd_err", {cnt_rd, cnt_err}, 0);
        check("t1_cmd_ready_after", cmd_ready, 1);
        check("t1_prot", {m_axil_awprot, m_axil_arprot}, 0);

        // W accepted immediately, AW delayed by 4 cycles.
        do_reset();
        aw_delay = 4;
        exp_awaddr = 40'h44;
        send(1, 40'h44, 32'hA5A50F0F, 4'h3, acc);
        wait_rsp(at);
        check("t2_w_cyc", w_cyc, acc + 1);
        check("t2_aw_cyc", aw_cyc, acc + 5);
        check("t2_b_cyc", b_cyc, acc + 6);
        check("t2_rsp_cyc", at, acc + 7);
        repeat (3) @(negedge clk);
        check("t2_valid_after_hs", viol, 0);
        check("t2_awaddr_stable", addr_unstable, 0);
        check("t2_hs_counts", {8'(aw_hs), 8'(w_hs), 8'(b_hs), 8'(rsp_hs)}, 32'h01010101);
        check("t2_wstrb", wstrb_hs, 4'h3);

        // Read with a 5-cycle R delay.
        do_reset();
        r_delay = 5; rdata_cfg = 32'h12345678;
        send(0, 40'h20, 32'hFFFFFFFF, 4'hF, acc);
        wait_rsp(at);
        check("t3_ar_cyc", ar_cyc, acc + 1);
        check("t3_r_cyc", r_cyc, acc + 7);
        check("t3_rsp_cyc", at, acc + 8);
        check("t3_araddr", araddr_hs, 40'h20);
        check("t3_rready_held", rready_gap, 0);
        check("t3_rsp", {r_rdata, r_resp, r_write}, {32'h12345678, 2'd0, 1'b0});
        @(negedge clk);
        check("t3_cnts", {cnt_wr, cnt_rd, cnt_err}, {4'd0, 4'd1, 4'd0});

        // Error responses.
        do_reset();
        bresp_cfg = 2'd2; exp_awaddr = 40'h30;
        send(1, 40'h30, 32'h0BADF00D, 4'hF, acc);
        wait_rsp(at);
        check("t4_bresp", {r_resp, r_write}, {2'd2, 1'b1});
        rresp_cfg = 2'd3; rdata_cfg = 32'hCAFEF00D;
        send(0, 40'h34, 32'h0, 4'h0, acc);
        wait_rsp(at);
        check("t4_rresp", {r_rdata, r_resp, r_write}, {32'hCAFEF00D, 2'd3, 1'b0});
        @(negedge clk);
        check("t4_cnts", {cnt_wr, cnt_rd, cnt_err}, {4'd1, 4'd1, 4'd2});

        // Back-to-back commands with a stalled response port.
        do_reset();
        rsp_ready = 0; exp_awaddr = 40'h50; rdata_cfg = 32'h55AA33CC;
        hs1 = -1; hold_err = 0; cmdrdy_err = 0;
        s_rdata = '0; s_resp = '0; s_write = 0;
        fork
            begin
                send(1, 40'h50, 32'h11112222, 4'hF, acc);
                send(0, 40'h54, 32'h0, 4'h0, acc2);
            end
            begin
                t = 0;
                while (!rsp_valid && t < 100) begin @(posedge clk); t++; end
                @(negedge clk);
                s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
                repeat (10) begin
                    @(negedge clk);
                    if (!rsp_valid || rsp_rdata != s_rdata || rsp_resp != s_resp || rsp_write != s_write)
                        hold_err++;
                    if (cmd_ready) cmdrdy_err++;
                end
                rsp_ready = 1;
                @(posedge clk);
                if (rsp_valid) hs1 = cyc;
                @(negedge clk);
                rsp_ready = 0;
            end
        join
        check("t5_first_rsp", {s_rdata, s_resp, s_write}, {32'h0, 2'd0, 1'b1});
        check("t5_rsp_stable", hold_err, 0);
        check("t5_cmd_ready_low", cmdrdy_err, 0);
        check("t5_second_accept", acc2, hs1 + 1);
        rsp_ready = 1;
        wait_rsp(at);
        check("t5_second_rsp", {r_rdata, r_resp, r_write}, {32'h55AA33CC, 2'd0, 1'b0});
        @(negedge clk);
        check("t5_cnts", {cnt_wr, cnt_rd}, {4'd1, 4'd1});

        // Reset while AW is stalled, then a clean write.
        do_reset();
        aw_delay = 1000; exp_awaddr = 40'h60;
        send(1, 40'h60, 32'h66666666, 4'hF, acc);
        repeat (2) @(negedge clk);
        check("t6_aw_pending", {m_axil_awvalid, m_axil_awready}, 2'b10);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_valids_cleared", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid}, 0);
        check("t6_readys_cleared", {m_axil_bready, m_axil_rready}, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_cnt", {cnt_wr, cnt_rd, cnt_err}, 0);
        aw_delay = 0; exp_awaddr = 40'h64;
        send(1, 40'h64, 32'h77777777, 4'hF, acc);
        wait_rsp(at);
        check("t6_rsp_cyc", at, acc + 3);
        check("t6_rsp", {r_resp, r_write}, {2'd0, 1'b1});
        @(negedge clk);
        check("t6_cnt_wr", cnt_wr, 1);
        check("t6_hs_counts", {8'(aw_hs), 8'(w_hs), 8'(b_hs)}, 24'h010101);

        // Counter saturation: cnt_wr holds at all-ones while cnt_err and cnt_rd still count.
        do_reset();
        exp_awaddr = 40'h70;
        for (int i = 0; i < 16; i++) begin
            send(1, 40'h70, 32'(i), 4'hF, acc);
            wait_rsp(at);
        end
        @(negedge clk);
        check("t7_cnt_wr_sat", cnt_wr, 4'hF);
        bresp_cfg = 2'd2;
        send(1, 40'h70, 32'h0, 4'hF, acc);
        wait_rsp(at);
        @(negedge clk);
        check("t7_cnt_wr_hold_err", {cnt_wr, cnt_err}, {4'hF, 4'd1});
        send(0, 40'h74, 32'h0, 4'h0, acc);
        wait_rsp(at);
        @(negedge clk);
        check("t7_cnt_rd", {cnt_wr, cnt_rd, cnt_err}, {4'hF, 4'd1, 4'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
